// File: rtl/intercon_switch_array.sv
// Array of NUM_XBAR crossbars whose routing is loaded through a length-checked serial shadow chain.
// Optional readback of the live configuration is enabled by defining INTERCON_READBACK_EN.
module intercon_switch_array #(
    parameter int NUM_XBAR  = 2,
    parameter int XBAR_PINS = 8,
    parameter int SEL_W     = 4
) (
    input  logic                              shift_clk,
    input  logic                              shift_rst_n,
    input  logic                              shift_en,
    input  logic                              shift_i,
    output logic                              shift_o,
    input  logic                              cfg_commit,
    input  logic                              cfg_clr,
    input  logic                              cfg_capture,
    input  logic [NUM_XBAR*XBAR_PINS-1:0]     pin_in,
    output logic [NUM_XBAR*XBAR_PINS-1:0]     pin_out,
    output logic [NUM_XBAR*XBAR_PINS-1:0]     pin_oe,
    output logic                              cfg_valid,
    output logic                              cfg_armed,
    output logic                              cfg_err,
    output logic [1:0]                        dbg_state
);

    localparam int NPIN  = NUM_XBAR * XBAR_PINS;
    localparam int CFG_W = NPIN * SEL_W;
    localparam int CNT_W = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0] CNT_ARMED = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CFG_W + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_ARMED   = 2'd2,
        ST_OVERRUN = 2'd3
    } state_e;

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    state_e           state_q, state_d;

    logic [CFG_W-1:0] shadow_shifted;
    logic [CNT_W-1:0] cnt_shifted;

`ifndef INTERCON_READBACK_EN
    logic unused_capture;
    assign unused_capture = cfg_capture;
`endif

    // The counter saturates one past full so an overlong stream stays distinguishable from ARMED.
    assign shadow_shifted = {shadow_q[CFG_W-2:0], shift_i};
    assign cnt_shifted    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (cfg_clr) begin
            shadow_d = '0;
            active_d = '0;
            cnt_d    = '0;
            valid_d  = 1'b0;
            err_d    = 1'b0;
        end else if (cfg_commit) begin
            if (state_q == ST_ARMED && !shift_en) begin
                active_d = shadow_q;
                valid_d  = 1'b1;
                cnt_d    = '0;
            end else begin
                err_d = 1'b1;
                if (shift_en) begin
                    shadow_d = shadow_shifted;
                    cnt_d    = cnt_shifted;
                end
            end
        end
`ifdef INTERCON_READBACK_EN
        else if (cfg_capture) begin
            shadow_d = active_q;
            cnt_d    = CNT_ARMED;
        end
`endif
        else if (shift_en) begin
            shadow_d = shadow_shifted;
            cnt_d    = cnt_shifted;
        end
    end

    always_comb begin
        state_d = ST_OVERRUN;
        if (cnt_d == '0) begin
            state_d = ST_EMPTY;
        end else if (cnt_d < CNT_ARMED) begin
            state_d = ST_LOADING;
        end else if (cnt_d == CNT_ARMED) begin
            state_d = ST_ARMED;
        end
    end

    always_ff @(posedge shift_clk or negedge shift_rst_n) begin
        if (!shift_rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= ST_EMPTY;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    // Routing only ever looks inside the pin's own crossbar; self-select and out-of-range codes stay off.
    always_comb begin
        int sel;
        sel     = 0;
        pin_out = '0;
        pin_oe  = '0;
        for (int x = 0; x < NUM_XBAR; x++) begin
            for (int p = 0; p < XBAR_PINS; p++) begin
                sel = 32'(active_q[(x*XBAR_PINS+p)*SEL_W +: SEL_W]);
                for (int s = 0; s < XBAR_PINS; s++) begin
                    if (sel == s + 1 && s != p) begin
                        pin_oe[x*XBAR_PINS+p]  = 1'b1;
                        pin_out[x*XBAR_PINS+p] = pin_in[x*XBAR_PINS+s];
                    end
                end
            end
        end
    end

    assign shift_o   = shadow_q[CFG_W-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;
    assign cfg_armed = (state_q == ST_ARMED);
    assign dbg_state = state_q;

endmodule
